// File: rtl/sysid_check_ctrl_if.sv
// Host read port between the board update portal and sysid_check_ctrl.
// slave modport is the checker side; master is the host driving reads.
interface sysid_check_ctrl_if;
    logic        host_address;
    logic        host_read;
    logic        host_waitrequest;
    logic [31:0] host_readdata;
    logic        host_readdatavalid;

    modport slave (
        input  host_address, host_read,
        output host_waitrequest, host_readdata, host_readdatavalid
    );

    modport master (
        output host_address, host_read,
        input  host_waitrequest, host_readdata, host_readdatavalid
    );
endinterface

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid ID/timestamp checker with retry, sharing the sysid slave with a host reader.
// Host arbitration and pending-start logic exist only when SYSID_CHECK_HOST_PORT_EN is defined.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'hFACECAFE,
    parameter logic [31:0] EXPECTED_TS  = 32'h511B3C8E,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned RETRY_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              sysid_address_o,
    input  logic [31:0]       sysid_readdata_i,
    sysid_check_ctrl_if.slave host,
    output logic              busy_o,
    output logic              done_o,
    output logic              id_ok_o,
    output logic              ts_ok_o,
    output logic [31:0]       captured_id_o,
    output logic [31:0]       captured_ts_o,
    output logic [3:0]        retry_cnt_o
);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, DONE} state_t;

    localparam logic [1:0] LAT  = 2'(READ_LATENCY);
    localparam logic [3:0] RMAX = 4'(RETRY_MAX);

    state_t      state_q;
    logic [1:0]  lat_q;
    logic [3:0]  retry_q;
    logic        busy_q, done_q, id_ok_q, ts_ok_q, addr_q;
    logic [31:0] cap_id_q, cap_ts_q;
    logic        lat_last, id_match, ts_match, go;

    assign lat_last = (lat_q == LAT);
    assign id_match = (cap_id_q == EXPECTED_ID);
    assign ts_match = (cap_ts_q == EXPECTED_TS);

`ifdef SYSID_CHECK_HOST_PORT_EN
    logic        hbusy_q, pend_q, hrdv_q;
    logic [1:0]  hcnt_q;
    logic [31:0] hrdata_q;
    logic        hdone, hacc;

    // A start in the same cycle as a host read wins: the host is stalled.
    assign host.host_waitrequest   = (state_q != DONE) | hbusy_q | start_i;
    assign host.host_readdata      = hrdata_q;
    assign host.host_readdatavalid = hrdv_q;
    assign hacc  = host.host_read & ~host.host_waitrequest;
    assign hdone = hbusy_q & (hcnt_q == LAT);
    // A start seen while a host read is in flight launches the check on the edge that read retires.
    assign go    = (start_i | pend_q) & (~hbusy_q | hdone);
`else
    logic unused_host;

    assign host.host_waitrequest   = 1'b1;
    assign host.host_readdata      = '0;
    assign host.host_readdatavalid = 1'b0;
    assign unused_host = host.host_address ^ host.host_read;
    assign go          = start_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            retry_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            addr_q   <= 1'b0;
            cap_id_q <= '0;
            cap_ts_q <= '0;
`ifdef SYSID_CHECK_HOST_PORT_EN
            hbusy_q  <= 1'b0;
            pend_q   <= 1'b0;
            hrdv_q   <= 1'b0;
            hcnt_q   <= '0;
            hrdata_q <= '0;
`endif
        end else begin
`ifdef SYSID_CHECK_HOST_PORT_EN
            hrdv_q <= 1'b0;
            if (hdone) begin
                hrdata_q <= sysid_readdata_i;
                hrdv_q   <= 1'b1;
                hbusy_q  <= 1'b0;
            end else if (hbusy_q) begin
                hcnt_q <= hcnt_q + 2'd1;
            end
`endif
            case (state_q)
                IDLE: begin
                    state_q <= RD_ID;
                    busy_q  <= 1'b1;
                    lat_q   <= '0;
                    addr_q  <= 1'b0;
                end
                RD_ID: begin
                    if (lat_last) begin
                        cap_id_q <= sysid_readdata_i;
                        state_q  <= RD_TS;
                        addr_q   <= 1'b1;
                        lat_q    <= '0;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                RD_TS: begin
                    if (lat_last) begin
                        cap_ts_q <= sysid_readdata_i;
                        state_q  <= CMP;
                        lat_q    <= '0;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                CMP: begin
                    id_ok_q <= id_match;
                    ts_ok_q <= ts_match;
                    if ((id_match && ts_match) || (retry_q >= RMAX)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        retry_q <= retry_q + 4'd1;
                        state_q <= RD_ID;
                        lat_q   <= '0;
                        addr_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (go) begin
                        state_q <= RD_ID;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        retry_q <= '0;
                        lat_q   <= '0;
                        addr_q  <= 1'b0;
`ifdef SYSID_CHECK_HOST_PORT_EN
                        pend_q  <= 1'b0;
`endif
                    end
`ifdef SYSID_CHECK_HOST_PORT_EN
                    else begin
                        if (start_i) pend_q <= 1'b1;
                        if (hacc) begin
                            hbusy_q <= 1'b1;
                            hcnt_q  <= '0;
                            addr_q  <= host.host_address;
                        end
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sysid_address_o = addr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign id_ok_o         = id_ok_q;
    assign ts_ok_o         = ts_ok_q;
    assign captured_id_o   = cap_id_q;
    assign captured_ts_o   = cap_ts_q;
    assign retry_cnt_o     = retry_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Self-checking bench for sysid_check_ctrl: latency-modelled sysid stub, randomized mismatch
// patterns and an outcome model; host-port expectations follow SYSID_CHECK_HOST_PORT_EN.
module tb_sysid_check_ctrl;
    localparam logic [31:0] EXP_ID = 32'hFACECAFE;
    localparam logic [31:0] EXP_TS = 32'h511B3C8E;
    localparam int RL   = 2;
    localparam int RMAX = 3;
    localparam int PASS = 2*RL + 3;
    localparam int AI   = (RL > 0) ? RL - 1 : 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sysid_address;
    logic [31:0] sysid_readdata;
    logic        busy, done, id_ok, ts_ok;
    logic [31:0] cap_id, cap_ts;
    logic [3:0]  retry;

    int ncmp = 0;
    int nerr = 0;

    // Stub: ID wrong while fewer than b_id ID words have been captured, TS wrong in the first b_ts passes.
    int          b_id = 0, b_ts = 0, passes = 0, base = 0;
    logic [31:0] bad_id = 32'h0, bad_ts = 32'h0;
    logic [3:0]  a_hist = '0;
    logic        prev_a = 1'b0;
    logic        rd_a;
    int          np;

    int          m_r;
    logic        m_iok, m_tok;
    logic [31:0] m_cid, m_cts;

    sysid_check_ctrl_if hbus();

    sysid_check_ctrl #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .READ_LATENCY(RL),
        .RETRY_MAX   (RMAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .sysid_address_o (sysid_address),
        .sysid_readdata_i(sysid_readdata),
        .host            (hbus),
        .busy_o          (busy),
        .done_o          (done),
        .id_ok_o         (id_ok),
        .ts_ok_o         (ts_ok),
        .captured_id_o   (cap_id),
        .captured_ts_o   (cap_ts),
        .retry_cnt_o     (retry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) a_hist <= {a_hist[2:0], sysid_address};

    always @(negedge clk) begin
        if (busy && !prev_a && sysid_address) passes <= passes + 1;
        prev_a <= sysid_address;
    end

    always_comb begin
        rd_a = (RL == 0) ? sysid_address : a_hist[AI];
        np   = passes - base;
        if (!rd_a) sysid_readdata = (np < b_id)  ? bad_id : EXP_ID;
        else       sysid_readdata = (np <= b_ts) ? bad_ts : EXP_TS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Outcome from the rules: first clean pass is max(b_id,b_ts), capped by the retry budget.
    task automatic model();
        int fp;
        fp    = (b_id > b_ts) ? b_id : b_ts;
        m_r   = (fp < RMAX) ? fp : RMAX;
        m_iok = (m_r >= b_id);
        m_tok = (m_r >= b_ts);
        m_cid = m_iok ? EXP_ID : bad_id;
        m_cts = m_tok ? EXP_TS : bad_ts;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"},   busy, 0);
        chk({tag, " done"},   done, 0);
        chk({tag, " id_ok"},  id_ok, 0);
        chk({tag, " ts_ok"},  ts_ok, 0);
        chk({tag, " retry"},  retry, 0);
        chk({tag, " cap_id"}, cap_id, 0);
        chk({tag, " cap_ts"}, cap_ts, 0);
        chk({tag, " addr"},   sysid_address, 0);
        chk({tag, " rdv"},    hbus.host_readdatavalid, 0);
        chk({tag, " rdata"},  hbus.host_readdata, 0);
        chk({tag, " wreq"},   hbus.host_waitrequest, 1);
    endtask

    task automatic start_check();
        @(negedge clk);
        start = 1'b1;
        base  = passes;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after the check-entry edge; counts edges until done is seen.
    task automatic run_check(input string tag, input bit poke);
        int k = 0;
        int spur = 0;
        model();
        while (k < 300) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (hbus.host_readdatavalid) spur++;
            if (k == 1) begin
                chk({tag, " busy run"}, busy, 1);
                chk({tag, " done run"}, done, 0);
            end
            if (poke) start = (k == 2);
            if (done) break;
        end
        start = 1'b0;
        chk({tag, " cycles"}, k, (m_r + 1) * PASS);
        chk({tag, " busy end"}, busy, 0);
        chk({tag, " retry"}, retry, 32'(m_r));
        chk({tag, " id_ok"}, id_ok, m_iok);
        chk({tag, " ts_ok"}, ts_ok, m_tok);
        chk({tag, " cap_id"}, cap_id, m_cid);
        chk({tag, " cap_ts"}, cap_ts, m_cts);
        chk({tag, " no rdv"}, spur, 0);
    endtask

`ifdef SYSID_CHECK_HOST_PORT_EN
    // Must be entered at a negedge while the DUT sits idle in DONE.
    task automatic host_rd(input string tag, input logic a);
        int k = 0;
        logic [31:0] w;
        w = a ? ((m_r + 1 <= b_ts) ? bad_ts : EXP_TS) : ((m_r + 1 < b_id) ? bad_id : EXP_ID);
        hbus.host_read    = 1'b1;
        hbus.host_address = a;
        #1 chk({tag, " wreq idle"}, hbus.host_waitrequest, 0);
        @(posedge clk);
        #1 hbus.host_read = 1'b0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (hbus.host_readdatavalid) break;
            chk({tag, " wreq busy"}, hbus.host_waitrequest, 1);
        end
        chk({tag, " lat"}, k, RL + 1);
        chk({tag, " data"}, hbus.host_readdata, w);
        @(negedge clk);
        chk({tag, " pulse"}, hbus.host_readdatavalid, 0);
    endtask
`endif

    initial begin
        hbus.host_read    = 1'b0;
        hbus.host_address = 1'b0;

        // Power-on reset and first automatic check
        repeat (3) @(negedge clk);
        chk_reset("por");
        base  = passes;
        rst_n = 1'b1;
        @(posedge clk);
        run_check("first", 0);

        b_id = 2; bad_id = 32'h0;
        start_check();
        run_check("retry2", 1);

        b_id = 9; bad_id = 32'h0BAD0001;
        start_check();
        run_check("nofix", 0);

        b_id = 0; b_ts = 0;
        start_check();
        run_check("clean", 0);

`ifdef SYSID_CHECK_HOST_PORT_EN
        host_rd("hts", 1'b1);
        @(negedge clk);
        host_rd("hid", 1'b0);

        // start during an in-flight host read is deferred to the retiring edge
        @(negedge clk);
        hbus.host_read    = 1'b1;
        hbus.host_address = 1'b1;
        #1 chk("pend wreq idle", hbus.host_waitrequest, 0);
        @(posedge clk);
        #1 hbus.host_read = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base  = passes;
        #1 chk("pend wreq", hbus.host_waitrequest, 1);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (RL) @(posedge clk);
        @(negedge clk);
        chk("pend rdv", hbus.host_readdatavalid, 1);
        chk("pend data", hbus.host_readdata, EXP_TS);
        chk("pend busy", busy, 1);
        run_check("pend", 0);

        // start and host_read together: checker wins
        hbus.host_read    = 1'b1;
        hbus.host_address = 1'b0;
        start = 1'b1;
        base  = passes;
        #1 chk("coll wreq", hbus.host_waitrequest, 1);
        @(posedge clk);
        #1 start = 1'b0;
        run_check("coll", 0);
        host_rd("coll host", 1'b0);

        // reset during a host read
        @(negedge clk);
        hbus.host_read    = 1'b1;
        hbus.host_address = 1'b1;
        @(posedge clk);
        #1 hbus.host_read = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_host");
        repeat (RL + 2) @(negedge clk);
        chk("rst_host held rdv", hbus.host_readdatavalid, 0);
        base  = passes;
        rst_n = 1'b1;
        @(posedge clk);
        run_check("after rst_host", 0);
`else
        // host port absent: requests are never accepted
        begin
            int bad = 0;
            @(negedge clk);
            hbus.host_read    = 1'b1;
            hbus.host_address = 1'b1;
            repeat (2 * PASS) begin
                #1;
                if (hbus.host_waitrequest !== 1'b1 || hbus.host_readdatavalid !== 1'b0) bad++;
                @(negedge clk);
            end
            chk("nohost stalls", bad, 0);
            chk("nohost rdata", hbus.host_readdata, 0);
        end
        start_check();
        run_check("nohost check", 0);
        hbus.host_read = 1'b0;
`endif

        // reset during RD_TS
        b_id = 0; b_ts = 0;
        start_check();
        repeat (RL + 1) @(posedge clk);
        #2;
        chk("rst_ts addr", sysid_address, 1);
        chk("rst_ts busy", busy, 1);
        rst_n = 1'b0;
        #1 chk_reset("rst_ts");
        @(negedge clk);
        @(negedge clk);
        base  = passes;
        rst_n = 1'b1;
        @(posedge clk);
        run_check("after rst_ts", 0);

        for (int i = 0; i < 6; i++) begin
            b_id   = $urandom_range(0, 5);
            b_ts   = $urandom_range(0, 5);
            bad_id = $urandom();
            bad_ts = $urandom();
            if (bad_id == EXP_ID) bad_id = bad_id ^ 32'h1;
            if (bad_ts == EXP_TS) bad_ts = bad_ts ^ 32'h1;
            start_check();
            run_check($sformatf("rand%0d", i), (i % 2) == 1);
`ifdef SYSID_CHECK_HOST_PORT_EN
            host_rd($sformatf("rand%0d host", i), 1'($urandom_range(0, 1)));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
